smoldvi_width_gearbox: RTL and testbench

//  Single-clock, parametrised width converter: W_IN-bit words in, W_OUT-bit words out, any ratio.

---
 rtl/smoldvi_width_gearbox.sv | 119 +++++++++++
 tb/tb_smoldvi_width_gearbox.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/smoldvi_width_gearbox.sv
// LSB-first W_IN -> W_OUT width converter built on a bit shifter with valid/ready on both sides.
// Optional sticky underrun flag enabled by defining SMOLDVI_GEARBOX_UNDERRUN_EN.
module smoldvi_width_gearbox #(
    parameter int unsigned W_IN     = 10,
    parameter int unsigned W_OUT    = 2,
    parameter int unsigned BUF_BITS = W_IN + W_OUT,
    parameter int unsigned W_LEVEL  = $clog2(BUF_BITS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W_IN-1:0]    din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_OUT-1:0]   dout,
`ifdef SMOLDVI_GEARBOX_UNDERRUN_EN
    output logic               underrun,
    input  logic               clr_underrun,
`endif
    output logic [W_LEVEL-1:0] level
);

    localparam logic [W_LEVEL-1:0]  IN_LIMIT = W_LEVEL'(BUF_BITS - W_IN);
    localparam logic [W_LEVEL-1:0]  OUT_MIN  = W_LEVEL'(W_OUT);
    localparam logic [W_LEVEL-1:0]  IN_STEP  = W_LEVEL'(W_IN);
    localparam logic [BUF_BITS-1:0] IN_MASK  = BUF_BITS'({W_IN{1'b1}});

    generate
        if (BUF_BITS < W_IN + W_OUT - 1) begin : g_bad_cfg
            $error("smoldvi_width_gearbox: BUF_BITS must be >= W_IN+W_OUT-1");
        end
    endgenerate

    logic [BUF_BITS-1:0] buf_q, buf_d;
    logic [W_LEVEL-1:0]  level_q, level_d;
    logic [BUF_BITS-1:0] shifted;
    logic [W_LEVEL-1:0]  base;
    logic                push, pop;

    // Handshake depends only on registered level, never on out_ready.
    assign in_ready  = !flush && (level_q <= IN_LIMIT);
    assign out_valid = !flush && (level_q >= OUT_MIN);
    assign dout      = buf_q[W_OUT-1:0];
    assign level     = level_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        shifted = pop ? (buf_q >> W_OUT) : buf_q;
        base    = pop ? (level_q - OUT_MIN) : level_q;
        buf_d   = shifted;
        level_d = base;
        if (push) begin
            // Clear stale bits above the fill point before inserting the new word.
            buf_d   = (shifted & ~(IN_MASK << base)) | (BUF_BITS'(din) << base);
            level_d = base + IN_STEP;
        end
        if (flush) begin
            level_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

`ifdef SMOLDVI_GEARBOX_UNDERRUN_EN
    logic started_q;
    logic underrun_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            started_q <= 1'b0;
        end else if (pop) begin
            started_q <= 1'b1;
        end
    end

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= 1'b0;
        end else if (started_q && out_ready && !out_valid && !flush) begin
            underrun_q <= 1'b1;
        end else if (clr_underrun) begin
            underrun_q <= 1'b0;
        end
    end

    assign underrun = underrun_q;
`endif

`ifndef SYNTHESIS
    logic            stall_q;
    logic [W_IN-1:0] din_q;

    always_ff @(posedge clk) begin
        stall_q <= !rst && in_valid && !in_ready;
        din_q   <= din;
        if (!rst) begin
            assert (level_q <= W_LEVEL'(BUF_BITS));
            if (stall_q && in_valid) begin
                assert (din == din_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_smoldvi_width_gearbox.sv
// Directed bench for smoldvi_width_gearbox: a 10->2/BUF 12 instance and a 10->4/BUF 13 instance.
module tb_smoldvi_width_gearbox;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_flush, a_in_valid, a_out_ready, a_in_ready, a_out_valid;
    logic [9:0] a_din;
    logic [1:0] a_dout;
    logic [3:0] a_level;
    logic       b_flush, b_in_valid, b_out_ready, b_in_ready, b_out_valid;
    logic [9:0] b_din;
    logic [3:0] b_dout;
    logic [3:0] b_level;
`ifdef SMOLDVI_GEARBOX_UNDERRUN_EN
    logic       a_underrun, a_clr_underrun, b_underrun, b_clr_underrun;
`endif

    int checks   = 0;
    int failures = 0;

    smoldvi_width_gearbox #(.W_IN(10), .W_OUT(2), .BUF_BITS(12)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .din(a_din),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .dout(a_dout),
`ifdef SMOLDVI_GEARBOX_UNDERRUN_EN
        .underrun(a_underrun), .clr_underrun(a_clr_underrun),
`endif
        .level(a_level)
    );

    smoldvi_width_gearbox #(.W_IN(10), .W_OUT(4), .BUF_BITS(13)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout),
`ifdef SMOLDVI_GEARBOX_UNDERRUN_EN
        .underrun(b_underrun), .clr_underrun(b_clr_underrun),
`endif
        .level(b_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] t2 [5];
        logic [3:0] a_lv [4];
        bit         q[$];
        int         mlevel;
        bit         hold;
        bit         exp_ir, exp_ov, do_push, do_pop;
        logic [3:0] w;

        t2[0] = 2'b01; t2[1] = 2'b10; t2[2] = 2'b10; t2[3] = 2'b01; t2[4] = 2'b11;
        a_lv[0] = 4'd8; a_lv[1] = 4'd6; a_lv[2] = 4'd4; a_lv[3] = 4'd2;

        rst = 1'b1;
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_din = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_din = '0;
`ifdef SMOLDVI_GEARBOX_UNDERRUN_EN
        a_clr_underrun = 0; b_clr_underrun = 0;
`endif
        // Reset
        repeat (3) tick();
        check("rst_a_level", 32'(a_level), 32'd0);
        check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
        check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_b_level", 32'(b_level), 32'd0);
        check("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        rst = 1'b0;

        // Single word 0x369 out as 2-bit chunks
        a_din = 10'h369; a_in_valid = 1; a_out_ready = 1;
        #1;
        check("t2_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        a_in_valid = 0;
        check("t2_level", 32'(a_level), 32'd10);
        for (int i = 0; i < 5; i++) begin
            check("t2_out_valid", 32'(a_out_valid), 32'd1);
            check("t2_dout", 32'(a_dout), 32'(t2[i]));
            tick();
        end
        check("t2_drained_valid", 32'(a_out_valid), 32'd0);
        check("t2_drained_level", 32'(a_level), 32'd0);

        // Reset mid-stream drops buffered bits
        a_out_ready = 0; a_din = 10'h3FF; a_in_valid = 1;
        tick();
        a_in_valid = 0;
        check("mrst_level_before", 32'(a_level), 32'd10);
        rst = 1; tick(); rst = 0;
        check("mrst_level", 32'(a_level), 32'd0);
        check("mrst_out_valid", 32'(a_out_valid), 32'd0);
        check("mrst_in_ready", 32'(a_in_ready), 32'd1);

        // Backpressure
        a_out_ready = 0; a_in_valid = 1; a_din = 10'h2A5;
        tick();
        check("bp_level_first", 32'(a_level), 32'd10);
        check("bp_in_ready_full", 32'(a_in_ready), 32'd0);
        tick();
        check("bp_level_hold", 32'(a_level), 32'd10);
        check("bp_in_ready_hold", 32'(a_in_ready), 32'd0);
        a_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_level_drain", 32'(a_level), 32'(a_lv[i]));
            check("bp_in_ready_drain", 32'(a_in_ready), (i == 3) ? 32'd1 : 32'd0);
        end
        check("bp_dout_tail", 32'(a_dout), 32'd2);
        tick();
        a_in_valid = 0;
        check("bp_level_pushpop", 32'(a_level), 32'd10);
        check("bp_dout_newword", 32'(a_dout), 32'd1);
        repeat (5) tick();
        check("bp_drained", 32'(a_level), 32'd0);

        // Flush at level 6
        a_out_ready = 0; a_din = 10'h3FF; a_in_valid = 1;
        tick();
        a_in_valid = 0; a_out_ready = 1;
        tick(); tick();
        a_out_ready = 0;
        check("fl_level6", 32'(a_level), 32'd6);
        a_flush = 1; a_in_valid = 1; a_din = 10'h369;
        #1;
        check("fl_in_ready", 32'(a_in_ready), 32'd0);
        check("fl_out_valid", 32'(a_out_valid), 32'd0);
        tick();
        a_flush = 0;
        check("fl_level0", 32'(a_level), 32'd0);
        check("fl_out_valid_after", 32'(a_out_valid), 32'd0);
        a_out_ready = 1;
        tick();
        a_in_valid = 0;
        check("fl_level_push", 32'(a_level), 32'd10);
        check("fl_dout0", 32'(a_dout), 32'd1);
        tick();
        check("fl_dout1", 32'(a_dout), 32'd2);
        repeat (4) tick();
        check("fl_drained", 32'(a_level), 32'd0);
        a_out_ready = 0;

`ifdef SMOLDVI_GEARBOX_UNDERRUN_EN
        // Underrun flag
        a_clr_underrun = 1; tick(); a_clr_underrun = 0;
        check("ur_cleared", 32'(a_underrun), 32'd0);
        a_din = 10'h369; a_in_valid = 1; a_out_ready = 1;
        tick();
        a_in_valid = 0;
        repeat (5) tick();
        check("ur_no_set_yet", 32'(a_underrun), 32'd0);
        tick();
        check("ur_set", 32'(a_underrun), 32'd1);
        a_out_ready = 0;
        a_clr_underrun = 1; tick(); a_clr_underrun = 0;
        check("ur_clr", 32'(a_underrun), 32'd0);
`endif

        // 10->4 random traffic against a bit-queue model
        mlevel = 0;
        hold   = 0;
        for (int c = 0; c < 600; c++) begin
            if (!hold) begin
                b_in_valid = ($urandom_range(0, 3) != 0);
                b_din      = 10'($urandom);
            end
            b_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_ir  = (mlevel <= 3);
            exp_ov  = (mlevel >= 4);
            check("nr_in_ready", 32'(b_in_ready), 32'(exp_ir));
            check("nr_out_valid", 32'(b_out_valid), 32'(exp_ov));
            do_push = b_in_valid && exp_ir;
            do_pop  = b_out_ready && exp_ov;
            if (do_pop) begin
                for (int k = 0; k < 4; k++) w[k] = q.pop_front();
                check("nr_dout", 32'(b_dout), 32'(w));
                mlevel -= 4;
            end
            if (do_push) begin
                for (int k = 0; k < 10; k++) q.push_back(b_din[k]);
                mlevel += 10;
            end
            hold = b_in_valid && !do_push;
            tick();
            check("nr_level", 32'(b_level), 32'(mlevel));
            check("nr_level_bound", 32'(b_level <= 4'd13), 32'd1);
        end
        b_in_valid = 0; b_out_ready = 1;
        for (int c = 0; c < 10 && mlevel >= 4; c++) begin
            for (int k = 0; k < 4; k++) w[k] = q.pop_front();
            check("nr_drain_dout", 32'(b_dout), 32'(w));
            mlevel -= 4;
            tick();
        end
        check("nr_drain_level", 32'(b_level), 32'(mlevel));
        check("nr_queue_size", 32'(q.size()), 32'(mlevel));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
